seven_seg_capture: RTL
======================

# seven_seg_capture

Receive-side counterpart of the multiplexed seven-segment driver: samples the time-multiplexed `{select, segments}` bus, waits for each digit dwell to settle, and rebuilds the per-digit segment bytes into a parallel frame. It also decodes every byte back to a hex nibble. It sits between a display bus (on-board loopback or an external panel tap) and any logic that needs to read the displayed values, e.g. self-test and scoreboards.

## Interface
- `NUMCELLS`, default 4: number of digits; must be ≥2.
- `SETTLE`, default 4: consecutive identical samples required before a dwell is captured; must be ≥1.
- `clock` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sig` in NUMCELLS+8: bus `{sel, seg}`.
  - `sel = sig[NUMCELLS+7:8]`, active-low digit select.
  - `seg = sig[7:0]`, active-high segments: bit0=A … bit6=G, bit7=DP.
- `cellval` out 8*NUMCELLS: last complete frame; digit k (select bit k low) in `[8k+7:8k]`.
- `hexval` out 4*NUMCELLS: decoded nibble per digit; digit k in `[4k+3:4k]`.
- `hexok` out NUMCELLS: bit k = 1 when digit k bits [6:0] matched a hex glyph.
- `frame_valid` out 1: one-cycle pulse when `cellval`/`hexval`/`hexok` update.
- `sel_err` out 1: one-cycle pulse when a settled sample has more than one select bit low.

## Operation
- **Input stage:** `sig_q <= sig` every cycle.
- **Stability counter `stab`:**
  - Width is clog2(SETTLE+1).
  - If `sig != sig_q`, `stab <= 0`; otherwise `stab <= min(stab+1, SETTLE)`.
- **Capture event:** occurs on the edge where `stab` goes SETTLE-1 → SETTLE with `sig == sig_q`. Exactly one event per dwell, and no re-capture while the bus holds.
- **At a capture event, decided by `sel`:**
  - Exactly one bit k low: `shadow[k] <= seg`, `seen[k] <= 1`.
  - All ones (blanking): ignored.
  - Two or more low: nothing is stored, and `sel_err` pulses on the next cycle.
- **Repeated digit before frame complete:** the later value overwrites `shadow[k]`; `seen[k]` stays 1.
- **Frame publish:** when `seen` is all ones, on the next edge:
  - `cellval <= shadow`;
  - `hexval`/`hexok` are loaded from the decode of `shadow`;
  - `frame_valid <= 1`;
  - `seen <= 0`.
- **Publish coinciding with a capture:** the capture on that same edge writes `shadow` and sets its `seen` bit after the clear. It counts toward the next frame.
- **Decode (DP ignored), patterns on bits [6:0]:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern: nibble 0, `hexok` bit 0.
- **Held outputs:** outputs keep their values between publishes; there is no partial-frame update.

## Timing
- **Reset (synchronous):**
  - `cellval`=0, `hexval`=0, `hexok`=0, `frame_valid`=0, `sel_err`=0;
  - `stab`=0, `seen`=0, `shadow`=0;
  - `sig_q`={NUMCELLS{1'b1}, 8'h00}.
- **Reset during a partial frame** discards it; capture restarts clean after reset deasserts.
- **Capture latency:** if `sig` first shows a new value at edge E and holds, `shadow` is written at edge E+SETTLE.
- **Publish latency:** the final digit captured at edge C gives `frame_valid` high in cycle C+1, with new `cellval` visible that same cycle.
- **Minimum dwell:** SETTLE+1 cycles. Shorter dwells are never captured.
- **Pulse widths:** `frame_valid` and `sel_err` are single-cycle pulses, registered, with no combinational path from `sig`.

## Test plan
- **Basic frame:** NUMCELLS=4, SETTLE=4, dwells of 10 cycles each for sel=1110/1101/1011/0111 with seg=3F/06/5B/4F → one `frame_valid` pulse 5 cycles after the last dwell starts; `cellval`=0x4F5B063F, `hexval`=0x3210, `hexok`=1111.
- **Glitch rejection:** a 3-cycle dwell inserted between digits → not captured; no `frame_valid` until all four full dwells are seen.
- **Overwrite and bad glyph:** digit 1 shown with 06 then 7F before digits 2–3 → `cellval[15:8]`=7F. A digit with seg=80 (DP only) → `hexok` bit 0, nibble 0.
- **Select error:** sel=1100 held 10 cycles → one `sel_err` pulse at capture+1, `seen` unchanged. sel=1111 blanking → no pulse, no capture.
- **Reset mid-frame:** reset for 1 cycle after 2 digits, then 4 full dwells → exactly one `frame_valid`, holding only post-reset values. All outputs read 0 during the cycle after reset.
- **Back-to-back frames:** continuous 6-cycle dwells for 3 frames → 3 `frame_valid` pulses spaced 24 cycles apart, no dropped digit.

Source files
------------

// File: rtl/seven_seg_capture_if.sv
// ----------------------------------------------------------------------------
// seven_seg_capture_if
// Bundles the sampled display bus and the rebuilt frame outputs of
// seven_seg_capture.
//   sig         : {sel, seg} display bus (sel active-low, seg active-high)
//   cellval     : last complete frame, digit k in [8k+7:8k]
//   hexval      : decoded nibble per digit, digit k in [4k+3:4k]
//   hexok       : bit k set when digit k matched a hex glyph
//   frame_valid : one-cycle pulse when the frame outputs update
//   sel_err     : one-cycle pulse for a settled sample with >1 select low
// master = bus source / frame consumer, slave = the capture block.
// ----------------------------------------------------------------------------
interface seven_seg_capture_if #(
    parameter int NUMCELLS = 4
);
    logic [NUMCELLS+7:0]   sig;
    logic [8*NUMCELLS-1:0] cellval;
    logic [4*NUMCELLS-1:0] hexval;
    logic [NUMCELLS-1:0]   hexok;
    logic                  frame_valid;
    logic                  sel_err;

    modport master (
        output sig,
        input  cellval, hexval, hexok, frame_valid, sel_err
    );

    modport slave (
        input  sig,
        output cellval, hexval, hexok, frame_valid, sel_err
    );
endinterface

// File: rtl/seven_seg_capture.sv
// ----------------------------------------------------------------------------
// seven_seg_capture
// Samples a time-multiplexed seven-segment bus, waits for each digit dwell to
// settle for SETTLE identical samples, collects one segment byte per digit
// and publishes the complete frame together with a per-digit hex decode.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : seven_seg_capture_if.slave (sig in; cellval/hexval/hexok,
//           frame_valid, sel_err out)
// ----------------------------------------------------------------------------

// Per-digit glyph decoder: segments A..G to hex nibble, DP excluded.
module seven_seg_capture_dec (
    input  logic [6:0] i_seg,
    output logic [3:0] o_nib,
    output logic       o_ok
);
    always_comb begin
        o_nib = 4'h0;
        o_ok  = 1'b1;
        case (i_seg)
            7'h3F: o_nib = 4'h0;
            7'h06: o_nib = 4'h1;
            7'h5B: o_nib = 4'h2;
            7'h4F: o_nib = 4'h3;
            7'h66: o_nib = 4'h4;
            7'h6D: o_nib = 4'h5;
            7'h7D: o_nib = 4'h6;
            7'h07: o_nib = 4'h7;
            7'h7F: o_nib = 4'h8;
            7'h6F: o_nib = 4'h9;
            7'h77: o_nib = 4'hA;
            7'h7C: o_nib = 4'hB;
            7'h39: o_nib = 4'hC;
            7'h5E: o_nib = 4'hD;
            7'h79: o_nib = 4'hE;
            7'h71: o_nib = 4'hF;
            default: begin
                o_nib = 4'h0;
                o_ok  = 1'b0;
            end
        endcase
    end
endmodule

module seven_seg_capture #(
    parameter int NUMCELLS = 4,
    parameter int SETTLE   = 4
) (
    input  logic                clock,
    input  logic                reset,
    seven_seg_capture_if.slave  bus
);
    localparam int            SW       = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE);
    localparam logic [SW-1:0] STAB_PRE = SW'(SETTLE - 1);

    // input stage and settle tracking
    logic [NUMCELLS+7:0]         r_sig_q;
    logic [SW-1:0]               r_stab;

    // frame assembly
    logic [NUMCELLS-1:0][7:0]    r_shadow;
    logic [NUMCELLS-1:0]         r_seen;

    // published outputs
    logic [NUMCELLS-1:0][7:0]    r_cellval;
    logic [NUMCELLS-1:0][3:0]    r_hexval;
    logic [NUMCELLS-1:0]         r_hexok;
    logic                        r_frame_valid;
    logic                        r_err_pend;
    logic                        r_sel_err;

    logic [NUMCELLS-1:0]         w_sel;
    logic [NUMCELLS-1:0]         w_nsel;
    logic [7:0]                  w_seg;
    logic                        w_same;
    logic                        w_cap;
    logic                        w_onehot;
    logic                        w_multi;
    logic                        w_full;
    logic [NUMCELLS-1:0]         w_seen_nxt;
    logic [NUMCELLS-1:0][3:0]    w_nib;
    logic [NUMCELLS-1:0]         w_ok;

    assign w_sel  = bus.sig[NUMCELLS+7:8];
    assign w_seg  = bus.sig[7:0];
    assign w_nsel = ~w_sel;
    assign w_same = (bus.sig == r_sig_q);

    // The counter saturates at SETTLE, so the SETTLE-1 -> SETTLE step
    // happens once per dwell and a held bus is never re-captured.
    assign w_cap = w_same && (r_stab == STAB_PRE);

    // Low selects as a mask: exactly one bit set means a valid digit.
    assign w_onehot = (w_nsel != '0) &&
                      ((w_nsel & (w_nsel - NUMCELLS'(1))) == '0);
    assign w_multi  = (w_nsel != '0) && !w_onehot;

    assign w_full = &r_seen;

    // Publish clears seen first; a capture on the same edge then counts
    // toward the following frame.
    assign w_seen_nxt = (w_full ? '0 : r_seen) |
                        ((w_cap && w_onehot) ? w_nsel : '0);

    for (genvar k = 0; k < NUMCELLS; k++) begin : g_dec
        seven_seg_capture_dec u_dec (
            .i_seg (r_shadow[k][6:0]),
            .o_nib (w_nib[k]),
            .o_ok  (w_ok[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sig_q       <= {{NUMCELLS{1'b1}}, 8'h00};
            r_stab        <= '0;
            r_shadow      <= '0;
            r_seen        <= '0;
            r_cellval     <= '0;
            r_hexval      <= '0;
            r_hexok       <= '0;
            r_frame_valid <= 1'b0;
            r_err_pend    <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            r_sig_q <= bus.sig;

            if (!w_same) begin
                r_stab <= '0;
            end else if (r_stab != STAB_MAX) begin
                r_stab <= SW'(r_stab + 1'b1);
            end

            if (w_cap && w_onehot) begin
                for (int k = 0; k < NUMCELLS; k++) begin
                    if (!w_sel[k]) begin
                        r_shadow[k] <= w_seg;
                    end
                end
            end
            r_seen <= w_seen_nxt;

            // Publish one edge after the frame completes, so frame_valid
            // and the new frame appear together.
            r_frame_valid <= w_full;
            if (w_full) begin
                r_cellval <= r_shadow;
                r_hexval  <= w_nib;
                r_hexok   <= w_ok;
            end

            // Select error reported one edge after the capture edge,
            // matching the frame_valid timing relative to its capture.
            r_err_pend <= w_cap && w_multi;
            r_sel_err  <= r_err_pend;
        end
    end

    assign bus.cellval     = r_cellval;
    assign bus.hexval      = r_hexval;
    assign bus.hexok       = r_hexok;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sel_err     = r_sel_err;
endmodule
